// File: rtl/lcd_glyph_writer.sv
// Streams one 16x16 glyph to a KS0108-style 128x64 LCD as page/column commands plus 32 data bytes.
// Define LCD_INIT_EN to add a power-up LCD reset pulse and display-on sequence after every reset.
module lcd_glyph_writer #(
  parameter int T_SETUP = 2,
  parameter int T_EN    = 8,
  parameter int T_HOLD  = 2,
  parameter int T_RST   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] glyph,
  input  logic [1:0]   slot_row,
  input  logic [2:0]   slot_col,
  output logic         busy,
  output logic         done,
  output logic         lcd_rst,
  output logic         lcd_cs1,
  output logic         lcd_cs2,
  output logic         lcd_rw,
  output logic         lcd_di,
  output logic         lcd_en,
  output logic [7:0]   lcd_data,
  output logic [2:0]   dbg_state
);

  localparam int W_LEN   = T_SETUP + T_EN + T_HOLD;
  localparam int CNT_MAX = (T_RST > W_LEN) ? T_RST : W_LEN;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] EN_ON  = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] EN_OFF = CW'(T_SETUP + T_EN - 1);
  localparam logic [CW-1:0] W_LAST = CW'(W_LEN - 1);
`ifdef LCD_INIT_EN
  localparam logic [CW-1:0] RST_LAST = CW'(T_RST - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SET_PAGE = 3'd1,
    S_SET_COL  = 3'd2,
    S_DATA     = 3'd3,
    S_FINISH   = 3'd4,
    S_INIT_RST = 3'd5,
    S_INIT_CMD = 3'd6
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            page_q;
  logic [3:0]      col_q;
  logic [255:0]    glyph_q;
  logic [1:0]      row_q;
  logic [1:0]      col_lo_q;
  logic            busy_q;
  logic            done_q;
  logic            cs1_q;
  logic            cs2_q;
  logic            di_q;
  logic            en_q;
  logic [7:0]      data_q;
`ifdef LCD_INIT_EN
  logic            lcd_rst_q;
  logic            init_sel_q;
`endif

  logic            in_write;
  logic [3:0]      col_d;
  logic [7:0]      data_byte_d;

  // Pixel (row 8p+b, column c) sits at glyph[255 - 16*(8p+b) - c], i.e. the bitwise
  // complement of the 8-bit index {p, b, c}.
  function automatic logic [7:0] col_byte(input logic [255:0] g, input logic p,
                                          input logic [3:0] c);
    logic [7:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      r[b] = g[~{p, 3'(b), c}];
    end
    return r;
  endfunction

  assign in_write    = (state_q == S_SET_PAGE) || (state_q == S_SET_COL) ||
                       (state_q == S_DATA) || (state_q == S_INIT_CMD);
  assign col_d       = (state_q == S_DATA) ? (col_q + 4'd1) : 4'd0;
  assign data_byte_d = col_byte(glyph_q, page_q, col_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      page_q   <= 1'b0;
      col_q    <= '0;
      glyph_q  <= '0;
      row_q    <= '0;
      col_lo_q <= '0;
      done_q   <= 1'b0;
      cs1_q    <= 1'b0;
      cs2_q    <= 1'b0;
      di_q     <= 1'b0;
      en_q     <= 1'b0;
      data_q   <= '0;
`ifdef LCD_INIT_EN
      state_q    <= S_INIT_RST;
      busy_q     <= 1'b1;
      lcd_rst_q  <= 1'b0;
      init_sel_q <= 1'b0;
`else
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      // Every bus write shares one phase counter: setup low, strobe high, hold low.
      if (in_write) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == EN_ON)  en_q <= 1'b1;
        if (cnt_q == EN_OFF) en_q <= 1'b0;
      end
      case (state_q)
        S_IDLE, S_FINISH: begin
          if (start) begin
            state_q  <= S_SET_PAGE;
            glyph_q  <= glyph;
            row_q    <= slot_row;
            col_lo_q <= slot_col[1:0];
            cnt_q    <= '0;
            page_q   <= 1'b0;
            busy_q   <= 1'b1;
            cs1_q    <= ~slot_col[2];
            cs2_q    <= slot_col[2];
            di_q     <= 1'b0;
            en_q     <= 1'b0;
            data_q   <= 8'hB8 | {5'b0, slot_row, 1'b0};
          end else if (state_q == S_FINISH) begin
            state_q <= S_IDLE;
            cs1_q   <= 1'b0;
            cs2_q   <= 1'b0;
          end
        end
        S_SET_PAGE: begin
          if (cnt_q == W_LAST) begin
            state_q <= S_SET_COL;
            cnt_q   <= '0;
            data_q  <= 8'h40 | {2'b00, col_lo_q, 4'b0000};
          end
        end
        S_SET_COL: begin
          if (cnt_q == W_LAST) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            col_q   <= '0;
            di_q    <= 1'b1;
            data_q  <= data_byte_d;
          end
        end
        S_DATA: begin
          if (cnt_q == W_LAST) begin
            cnt_q <= '0;
            if (col_q != 4'd15) begin
              col_q  <= col_d;
              data_q <= data_byte_d;
            end else if (!page_q) begin
              state_q <= S_SET_PAGE;
              page_q  <= 1'b1;
              di_q    <= 1'b0;
              data_q  <= 8'hB8 | {5'b0, row_q, 1'b1};
            end else begin
              state_q <= S_FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              di_q    <= 1'b0;
              data_q  <= '0;
            end
          end
        end
`ifdef LCD_INIT_EN
        S_INIT_RST: begin
          if (cnt_q == RST_LAST) begin
            state_q    <= S_INIT_CMD;
            cnt_q      <= '0;
            lcd_rst_q  <= 1'b1;
            init_sel_q <= 1'b0;
            cs1_q      <= 1'b1;
            cs2_q      <= 1'b0;
            di_q       <= 1'b0;
            data_q     <= 8'h3F;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_INIT_CMD: begin
          if (cnt_q == W_LAST) begin
            cnt_q <= '0;
            if (!init_sel_q) begin
              init_sel_q <= 1'b1;
              cs1_q      <= 1'b0;
              cs2_q      <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              cs2_q   <= 1'b0;
              data_q  <= '0;
            end
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef LCD_INIT_EN
  assign lcd_rst = lcd_rst_q;
`else
  assign lcd_rst = 1'b1;
`endif
  assign busy      = busy_q;
  assign done      = done_q;
  assign lcd_cs1   = cs1_q;
  assign lcd_cs2   = cs2_q;
  assign lcd_rw    = 1'b0;
  assign lcd_di    = di_q;
  assign lcd_en    = en_q;
  assign lcd_data  = data_q;
  assign dbg_state = state_q;

endmodule
